// File: rtl/tiny_riscv_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tiny_riscv_mem_arbiter_pkg
// Brief   : Shared constants, pending-read record and range helper for the
//           unified-memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package tiny_riscv_mem_arbiter_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 1536;

  localparam logic       GRANT_M0   = 1'b0;
  localparam logic       GRANT_M1   = 1'b1;
  localparam logic [3:0] WMASK_READ = 4'b0000;

  // One outstanding response: who gets it and whether it is an error.
  typedef struct packed {
    logic valid;
    logic owner;
    logic err;
  } pend_t;

  function automatic logic addr_in_range(input logic [29:0] word_idx,
                                         input int unsigned words);
    return {2'b00, word_idx} < words;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tiny_riscv_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin / fixed-priority picker with a last-grant flop.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2
  import tiny_riscv_mem_arbiter_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  input  logic       i_prio_mode,
  output logic       o_grant,
  output logic       o_grant_valid
);

  logic r_last;

  always_comb begin
    o_grant       = GRANT_M0;
    o_grant_valid = |i_req;
    case (i_req)
      2'b01:   o_grant = GRANT_M0;
      2'b10:   o_grant = GRANT_M1;
      // Conflict: fixed priority favours M1, otherwise hand over from last owner.
      2'b11:   o_grant = i_prio_mode ? GRANT_M1
                                     : ((r_last == GRANT_M0) ? GRANT_M1 : GRANT_M0);
      default: o_grant = GRANT_M0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_last <= GRANT_M1;
    end else if (i_accept) begin
      r_last <= o_grant;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tiny_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tiny_riscv_mem_arbiter
// Brief   : Shares single-port CPU memory between fetch (M0) and load/store
//           (M1) with range checking and one-cycle read return.
// Revision: 1.0 - initial release
// ============================================================================
module tiny_riscv_mem_arbiter
  import tiny_riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = MEM_WORDS_DEFAULT,
  parameter bit          M1_PRIORITY = 1'b0
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  output logic        o_m0_ready,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_err,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [3:0]  i_m1_wmask,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_ready,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_err,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_read_strobe,
  output logic [31:0] o_mem_write_data,
  output logic [3:0]  o_mem_write_mask,
  input  logic [31:0] i_mem_data
);

  logic        w_grant;
  logic        w_grant_valid;
  logic        w_accept;
  logic [31:0] w_sel_addr;
  logic [3:0]  w_sel_wmask;
  logic        w_in_range;
  logic        w_is_read;
  logic        w_pend_live;
  pend_t       r_pend;

  rr_arb2 u_arb (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .i_req         ({i_m1_req, i_m0_req}),
    .i_accept      (w_accept),
    .i_prio_mode   (M1_PRIORITY),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid)
  );

  assign w_accept   = w_grant_valid & ~i_Reset;
  assign o_m0_ready = w_accept & (w_grant == GRANT_M0);
  assign o_m1_ready = w_accept & (w_grant == GRANT_M1);

  always_comb begin
    w_sel_addr        = (w_grant == GRANT_M1) ? i_m1_addr  : i_m0_addr;
    w_sel_wmask       = (w_grant == GRANT_M1) ? i_m1_wmask : WMASK_READ;
    w_in_range        = addr_in_range(w_sel_addr[31:2], MEM_WORDS);
    w_is_read         = (w_sel_wmask == WMASK_READ);
    o_mem_addr        = 32'h0;
    o_mem_write_data  = 32'h0;
    o_mem_read_strobe = 1'b0;
    o_mem_write_mask  = WMASK_READ;
    if (w_accept) begin
      o_mem_addr       = w_sel_addr;
      o_mem_write_data = (w_grant == GRANT_M1) ? i_m1_wdata : 32'h0;
      // Out-of-range accesses are accepted but never reach the memory.
      if (w_in_range) begin
        o_mem_read_strobe = w_is_read;
        o_mem_write_mask  = w_sel_wmask;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_pend <= '0;
    end else begin
      r_pend.valid <= w_accept & (w_is_read | ~w_in_range);
      r_pend.owner <= w_grant;
      r_pend.err   <= ~w_in_range;
    end
  end

  // Responses are suppressed while reset is held so a read in flight is dropped.
  assign w_pend_live = r_pend.valid & ~i_Reset;

  assign o_m0_rvalid = w_pend_live & ~r_pend.err & (r_pend.owner == GRANT_M0);
  assign o_m1_rvalid = w_pend_live & ~r_pend.err & (r_pend.owner == GRANT_M1);
  assign o_m0_err    = w_pend_live &  r_pend.err & (r_pend.owner == GRANT_M0);
  assign o_m1_err    = w_pend_live &  r_pend.err & (r_pend.owner == GRANT_M1);

  assign o_m0_rdata = i_mem_data;
  assign o_m1_rdata = i_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_tiny_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_tiny_riscv_mem_arbiter
// Brief   : Self-checking bench with a memory device and a transaction-level
//           reference model of the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tiny_riscv_mem_arbiter;

  localparam int WORDS = 1536;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_m0_req;
  logic [31:0] i_m0_addr;
  logic        o_m0_ready, o_m0_rvalid, o_m0_err;
  logic [31:0] o_m0_rdata;
  logic        i_m1_req;
  logic [31:0] i_m1_addr;
  logic [3:0]  i_m1_wmask;
  logic [31:0] i_m1_wdata;
  logic        o_m1_ready, o_m1_rvalid, o_m1_err;
  logic [31:0] o_m1_rdata;
  logic [31:0] o_mem_addr, o_mem_write_data;
  logic        o_mem_read_strobe;
  logic [3:0]  o_mem_write_mask;
  logic [31:0] i_mem_data;

  always #5 i_Clk = ~i_Clk;

  tiny_riscv_mem_arbiter #(.MEM_WORDS(WORDS), .M1_PRIORITY(1'b0)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .o_m0_ready(o_m0_ready),
    .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata), .o_m0_err(o_m0_err),
    .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wmask(i_m1_wmask),
    .i_m1_wdata(i_m1_wdata), .o_m1_ready(o_m1_ready), .o_m1_rvalid(o_m1_rvalid),
    .o_m1_rdata(o_m1_rdata), .o_m1_err(o_m1_err),
    .o_mem_addr(o_mem_addr), .o_mem_read_strobe(o_mem_read_strobe),
    .o_mem_write_data(o_mem_write_data), .o_mem_write_mask(o_mem_write_mask),
    .i_mem_data(i_mem_data)
  );

  int checks = 0;
  int passes = 0;

  // Memory device: synchronous read, byte-lane writes, in-range only.
  logic [31:0] mem [0:WORDS-1];
  logic [31:0] mem_q;
  logic        seed_en;
  logic [31:0] salt;

  function automatic logic [31:0] seed_word(input int i, input logic [31:0] s);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ s;
  endfunction

  always @(posedge i_Clk) begin
    if (seed_en) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= seed_word(i, salt);
    end else begin
      if (o_mem_read_strobe && o_mem_addr[31:2] < WORDS)
        mem_q <= mem[o_mem_addr[12:2]];
      for (int b = 0; b < 4; b++)
        if (o_mem_write_mask[b] && o_mem_addr[31:2] < WORDS)
          mem[o_mem_addr[12:2]][8*b +: 8] <= o_mem_write_data[8*b +: 8];
    end
  end
  assign i_mem_data = mem_q;

  // Reference model state
  logic [31:0] ref_mem [0:WORDS-1];
  int          exp_last;
  logic        pend_v, pend_err;
  int          pend_owner;
  logic [31:0] pend_data;

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    int unsigned w;
    r = $urandom % 16;
    if (r == 0)      w = WORDS + ($urandom % 64);
    else if (r == 1) return $urandom | 32'h8000_0000;
    else             w = $urandom % WORDS;
    return (w << 2) | ($urandom & 3);
  endfunction

  task automatic test_reset();
    i_Reset = 1'b1; i_m0_req = 1'b1; i_m1_req = 1'b1; seed_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_Clk);
      checks++;
      if ({o_m0_ready, o_m1_ready, o_m0_rvalid, o_m1_rvalid, o_m0_err, o_m1_err,
           o_mem_read_strobe, o_mem_write_mask} !== 10'h0)
        $display("FAIL reset_hold: got rdy=%b%b rv=%b%b err=%b%b stb=%b mask=%b want all 0",
                 o_m0_ready, o_m1_ready, o_m0_rvalid, o_m1_rvalid, o_m0_err, o_m1_err,
                 o_mem_read_strobe, o_mem_write_mask);
      else passes++;
      @(posedge i_Clk); #1;
    end
    i_Reset = 1'b0; i_m0_req = 1'b0; i_m1_req = 1'b0; seed_en = 1'b0;
    exp_last = 1; pend_v = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge i_Clk);
      checks++;
      if ({o_m0_ready, o_m1_ready, o_m0_rvalid, o_m1_rvalid, o_m0_err, o_m1_err,
           o_mem_read_strobe, o_mem_write_mask, o_mem_addr} !== 42'h0)
        $display("FAIL reset_release: got rv=%b%b err=%b%b stb=%b addr=%h want idle",
                 o_m0_rvalid, o_m1_rvalid, o_m0_err, o_m1_err, o_mem_read_strobe, o_mem_addr);
      else passes++;
      @(posedge i_Clk); #1;
    end
  endtask

  task automatic test_lone_fetch();
    i_m0_req = 1'b1; i_m0_addr = 32'h10;
    @(negedge i_Clk);
    checks++;
    if ({o_m0_ready, o_m1_ready, o_mem_read_strobe, o_mem_write_mask} !== 7'b1010000 ||
        o_mem_addr !== 32'h10)
      $display("FAIL fetch_accept: got rdy=%b%b stb=%b mask=%b addr=%h want 10 1 0000 00000010",
               o_m0_ready, o_m1_ready, o_mem_read_strobe, o_mem_write_mask, o_mem_addr);
    else passes++;
    exp_last = 0;
    @(posedge i_Clk); #1;
    i_m0_req = 1'b0;
    @(negedge i_Clk);
    checks++;
    if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== ref_mem[4] || o_m1_rvalid !== 1'b0 || o_m0_err !== 1'b0)
      $display("FAIL fetch_data: got rv=%b data=%h m1rv=%b err=%b want 1 %h 0 0",
               o_m0_rvalid, o_m0_rdata, o_m1_rvalid, o_m0_err, ref_mem[4]);
    else passes++;
    @(posedge i_Clk); #1;
  endtask

  task automatic test_conflict_rr();
    int w;
    logic [31:0] a0, a1;
    a0 = ($urandom % WORDS) << 2; a1 = ($urandom % WORDS) << 2;
    i_m0_req = 1'b1; i_m1_req = 1'b1; i_m1_wmask = 4'h0;
    for (int c = 0; c <= 8; c++) begin
      if (c == 8) begin i_m0_req = 1'b0; i_m1_req = 1'b0; end
      i_m0_addr = a0; i_m1_addr = a1;
      @(negedge i_Clk);
      checks++;
      if ({o_m1_rvalid, o_m0_rvalid} !== {pend_v && pend_owner == 1, pend_v && pend_owner == 0} ||
          (pend_v && ((pend_owner == 0 ? o_m0_rdata : o_m1_rdata) !== pend_data)))
        $display("FAIL rr_return: got rv=%b%b d0=%h d1=%h want owner %0d data %h",
                 o_m1_rvalid, o_m0_rvalid, o_m0_rdata, o_m1_rdata, pend_owner, pend_data);
      else passes++;
      pend_v = 1'b0;
      if (c < 8) begin
        w = (exp_last == 0) ? 1 : 0;
        checks++;
        if ({o_m1_ready, o_m0_ready} !== (w == 1 ? 2'b10 : 2'b01) || o_mem_read_strobe !== 1'b1 ||
            o_mem_addr !== (w == 1 ? a1 : a0))
          $display("FAIL rr_grant: got rdy=%b%b stb=%b addr=%h want winner M%0d",
                   o_m1_ready, o_m0_ready, o_mem_read_strobe, o_mem_addr, w);
        else passes++;
        pend_v = 1'b1; pend_owner = w; pend_err = 1'b0;
        pend_data = ref_mem[(w == 1 ? a1 : a0) >> 2];
        exp_last = w;
        if (w == 1) a1 = ($urandom % WORDS) << 2; else a0 = ($urandom % WORDS) << 2;
      end
      @(posedge i_Clk); #1;
    end
  endtask

  task automatic test_store_load();
    logic [31:0] expw;
    i_m1_req = 1'b1; i_m1_addr = 32'h20; i_m1_wmask = 4'b0011; i_m1_wdata = 32'h11223344;
    @(negedge i_Clk);
    checks++;
    if (o_m1_ready !== 1'b1 || o_mem_write_mask !== 4'b0011 || o_mem_read_strobe !== 1'b0 ||
        o_mem_write_data !== 32'h11223344 || o_mem_addr[31:2] !== 30'd8)
      $display("FAIL store_issue: got rdy=%b mask=%b stb=%b wd=%h addr=%h want 1 0011 0 11223344 20",
               o_m1_ready, o_mem_write_mask, o_mem_read_strobe, o_mem_write_data, o_mem_addr);
    else passes++;
    expw = {ref_mem[8][31:16], 16'h3344};
    ref_mem[8] = expw;
    exp_last = 1;
    @(posedge i_Clk); #1;
    i_m1_wmask = 4'b0000;
    @(negedge i_Clk);
    checks++;
    if (o_m1_rvalid !== 1'b0 || o_m1_err !== 1'b0 || o_mem_read_strobe !== 1'b1 || o_mem_write_mask !== 4'h0)
      $display("FAIL load_issue: got rv=%b err=%b stb=%b mask=%b want 0 0 1 0000",
               o_m1_rvalid, o_m1_err, o_mem_read_strobe, o_mem_write_mask);
    else passes++;
    @(posedge i_Clk); #1;
    i_m1_req = 1'b0;
    @(negedge i_Clk);
    checks++;
    if (o_m1_rvalid !== 1'b1 || o_m1_rdata !== expw)
      $display("FAIL load_data: got rv=%b data=%h want 1 %h", o_m1_rvalid, o_m1_rdata, expw);
    else passes++;
    @(posedge i_Clk); #1;
  endtask

  task automatic test_out_of_range();
    i_m1_req = 1'b1; i_m1_addr = 32'h1800; i_m1_wmask = 4'h0;
    @(negedge i_Clk);
    checks++;
    if (o_m1_ready !== 1'b1 || o_mem_read_strobe !== 1'b0 || o_mem_write_mask !== 4'h0)
      $display("FAIL oor_read_issue: got rdy=%b stb=%b mask=%b want 1 0 0000",
               o_m1_ready, o_mem_read_strobe, o_mem_write_mask);
    else passes++;
    @(posedge i_Clk); #1;
    i_m1_wmask = 4'hF; i_m1_wdata = $urandom;
    @(negedge i_Clk);
    checks++;
    if (o_m1_err !== 1'b1 || o_m1_rvalid !== 1'b0 || o_m1_ready !== 1'b1 || o_mem_write_mask !== 4'h0)
      $display("FAIL oor_read_resp: got err=%b rv=%b rdy=%b mask=%b want 1 0 1 0000",
               o_m1_err, o_m1_rvalid, o_m1_ready, o_mem_write_mask);
    else passes++;
    @(posedge i_Clk); #1;
    i_m1_addr = 32'h17FC; i_m1_wmask = 4'h0;
    @(negedge i_Clk);
    checks++;
    if (o_m1_err !== 1'b1 || o_m1_rvalid !== 1'b0 || o_mem_read_strobe !== 1'b1)
      $display("FAIL oor_write_resp: got err=%b rv=%b stb=%b want 1 0 1",
               o_m1_err, o_m1_rvalid, o_mem_read_strobe);
    else passes++;
    @(posedge i_Clk); #1;
    i_m1_req = 1'b0;
    @(negedge i_Clk);
    checks++;
    if (o_m1_rvalid !== 1'b1 || o_m1_err !== 1'b0 || o_m1_rdata !== ref_mem[WORDS-1])
      $display("FAIL last_word_read: got rv=%b err=%b data=%h want 1 0 %h",
               o_m1_rvalid, o_m1_err, o_m1_rdata, ref_mem[WORDS-1]);
    else passes++;
    exp_last = 1;
    @(posedge i_Clk); #1;
  endtask

  task automatic test_reset_mid_read();
    i_m0_req = 1'b1; i_m0_addr = ($urandom % WORDS) << 2;
    @(negedge i_Clk);
    checks++;
    if (o_m0_ready !== 1'b1 || o_mem_read_strobe !== 1'b1)
      $display("FAIL rst_mid_accept: got rdy=%b stb=%b want 1 1", o_m0_ready, o_mem_read_strobe);
    else passes++;
    @(posedge i_Clk); #1;
    i_Reset = 1'b1; i_m0_req = 1'b0;
    @(negedge i_Clk);
    checks++;
    if (o_m0_rvalid !== 1'b0 || o_m0_err !== 1'b0)
      $display("FAIL rst_mid_rvalid: got rv=%b err=%b want 0 0", o_m0_rvalid, o_m0_err);
    else passes++;
    @(posedge i_Clk); #1;
    i_Reset = 1'b0;
    @(negedge i_Clk);
    checks++;
    if (o_m0_rvalid !== 1'b0 || o_m0_err !== 1'b0)
      $display("FAIL rst_mid_after: got rv=%b err=%b want 0 0", o_m0_rvalid, o_m0_err);
    else passes++;
    exp_last = 1; pend_v = 1'b0;
    @(posedge i_Clk); #1;
  endtask

  task automatic test_random_traffic();
    logic a0, a1, inr, rd;
    int w;
    logic [31:0] wa;
    logic [3:0] em;
    a0 = 1'b0; a1 = 1'b0; pend_v = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c < 298) begin
        if (!a0 && ($urandom % 3) != 0) begin a0 = 1'b1; i_m0_addr = rand_addr(); end
        if (!a1 && ($urandom % 3) != 0) begin
          a1 = 1'b1; i_m1_addr = rand_addr(); i_m1_wdata = $urandom;
          i_m1_wmask = ($urandom % 2) ? 4'h0 : 4'($urandom);
        end
      end else begin
        a0 = 1'b0; a1 = 1'b0;
      end
      i_m0_req = a0; i_m1_req = a1;
      @(negedge i_Clk);
      checks++;
      if ({o_m1_rvalid, o_m0_rvalid, o_m1_err, o_m0_err} !==
          {pend_v && !pend_err && pend_owner == 1, pend_v && !pend_err && pend_owner == 0,
           pend_v &&  pend_err && pend_owner == 1, pend_v &&  pend_err && pend_owner == 0} ||
          (pend_v && !pend_err && ((pend_owner == 0 ? o_m0_rdata : o_m1_rdata) !== pend_data)))
        $display("FAIL rand_resp c=%0d: got rv=%b%b err=%b%b d0=%h d1=%h want v=%b owner=%0d err=%b data=%h",
                 c, o_m1_rvalid, o_m0_rvalid, o_m1_err, o_m0_err, o_m0_rdata, o_m1_rdata,
                 pend_v, pend_owner, pend_err, pend_data);
      else passes++;
      if (a0 && a1) w = (exp_last == 0) ? 1 : 0;
      else if (a0)  w = 0;
      else if (a1)  w = 1;
      else          w = -1;
      wa  = (w == 1) ? i_m1_addr : i_m0_addr;
      inr = (w >= 0) && ((wa >> 2) < WORDS);
      rd  = (w == 0) || (i_m1_wmask == 4'h0);
      em  = (inr && w == 1) ? i_m1_wmask : 4'h0;
      checks++;
      if ({o_m1_ready, o_m0_ready} !== {w == 1, w == 0} ||
          o_mem_read_strobe !== (inr && rd) || o_mem_write_mask !== em ||
          o_mem_addr !== ((w >= 0) ? wa : 32'h0))
        $display("FAIL rand_issue c=%0d: got rdy=%b%b stb=%b mask=%b addr=%h want M%0d stb=%b mask=%b addr=%h",
                 c, o_m1_ready, o_m0_ready, o_mem_read_strobe, o_mem_write_mask, o_mem_addr,
                 w, inr && rd, em, (w >= 0) ? wa : 32'h0);
      else passes++;
      pend_v = 1'b0;
      if (w >= 0) begin
        pend_v = rd || !inr; pend_owner = w; pend_err = !inr;
        pend_data = inr ? ref_mem[wa >> 2] : 32'h0;
        if (inr && !rd)
          for (int b = 0; b < 4; b++)
            if (i_m1_wmask[b]) ref_mem[wa >> 2][8*b +: 8] = i_m1_wdata[8*b +: 8];
        exp_last = w;
        if (w == 0) a0 = 1'b0; else a1 = 1'b0;
      end
      @(posedge i_Clk); #1;
    end
  endtask

  initial begin
    i_Reset = 1'b1; i_m0_req = 1'b0; i_m1_req = 1'b0;
    i_m0_addr = 32'h0; i_m1_addr = 32'h0; i_m1_wmask = 4'h0; i_m1_wdata = 32'h0;
    seed_en = 1'b1; salt = $urandom;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = seed_word(i, salt);
    exp_last = 1; pend_v = 1'b0; pend_owner = 0; pend_err = 1'b0; pend_data = 32'h0;
    @(posedge i_Clk); #1;
    test_reset();
    test_lone_fetch();
    test_conflict_rr();
    test_store_load();
    test_out_of_range();
    test_reset_mid_read();
    test_random_traffic();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
